if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk_i  in  1  clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-low.
REQ-003 start_i  in  1  fetch enable; 0 holds the block in IDLE.
REQ-004 pc_i  in  32  current program counter from the PC register.
REQ-005 pipe_stall_i  in  1  decode stage cannot accept an instruction this cycle.
REQ-006 flush_i  in  1  branch/redirect; discards any in-flight or held fetch.
REQ-007 mem_ack_i  in  1  instruction memory returns data this cycle.
REQ-008 mem_data_i  in  32  instruction word, valid when mem_ack_i=1.
REQ-009 mem_req_o  out  1  memory read request.
REQ-010 mem_addr_o  out  32  request address, stable while mem_req_o=1.
REQ-011 instr_o  out  32  fetched instruction.
REQ-012 instr_pc_o  out  32  address of instr_o.
REQ-013 instr_valid_o  out  1  instr_o/instr_pc_o valid for decode.
REQ-014 stall_o  out  1  hold request to the PC register (PC advances only when 0).
REQ-015 misalign_o  out  1  instr_o produced from a misaligned pc (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, VALID, DROP; all transitions registered.
REQ-017 IDLE: start_i=1, flush_i=0 -> latch pc_i into address register, go REQ; otherwise stay IDLE.
REQ-018 REQ: mem_req_o=1, mem_addr_o=latched address, both held unchanged until mem_ack_i=1.
REQ-019 REQ with mem_ack_i=1, flush_i=0 -> capture mem_data_i into instr_o, address into instr_pc_o, go VALID.
REQ-020 REQ with flush_i=1: mem_ack_i=1 -> data discarded, go IDLE; mem_ack_i=0 -> go DROP.
REQ-021 DROP: mem_req_o=1 with unchanged address until mem_ack_i=1, then data discarded, go IDLE; flush_i in DROP has no additional effect.
REQ-022 VALID: instr_valid_o=1; pipe_stall_i=1 -> hold instr_o/instr_pc_o; pipe_stall_i=0 -> instruction consumed, go IDLE.
REQ-023 VALID with flush_i=1 -> go IDLE, instruction not consumed, regardless of pipe_stall_i.
REQ-024 instr_valid_o SHALL be 1 exactly in VALID; mem_req_o exactly in REQ and DROP.
REQ-025 stall_o SHALL be combinational: 0 when flush_i=1 or (state=VALID and pipe_stall_i=0); 1 otherwise, so the PC advances exactly once per consumed instruction or once per redirect.
REQ-026 mem_ack_i in IDLE or VALID SHALL be ignored.
REQ-027 Minimum throughput: one instruction per 3 cycles (IDLE, REQ with same-cycle ack, VALID accept).
REQ-028 instr_o and instr_pc_o SHALL retain last captured values outside VALID.

Reset
REQ-029 rst_i=0 SHALL force state IDLE and clear address register, instr_o, instr_pc_o, misalign_o to 0 immediately, including mid-REQ; a late mem_ack_i after reset release is ignored.
REQ-030 During reset mem_req_o=0, instr_valid_o=0, stall_o=1 unless flush_i=1.

Configuration
REQ-031 Macro IF_MISALIGN_CHK_EN defined: IDLE with start_i=1 and pc_i[1:0]!=0 SHALL skip REQ, go directly to VALID with instr_o=32'h00000000, instr_pc_o=pc_i, misalign_o=1; misalign_o cleared on leaving VALID.
REQ-032 IF_MISALIGN_CHK_EN undefined: pc_i[1:0] passed unmodified to mem_addr_o, no special handling, misalign_o tied 0.

Verification
REQ-033 Reset release, start_i=1, pc_i=0x0, mem_ack_i same cycle with data 0x00500093 -> instr_valid_o=1 two cycles after start, instr_o=0x00500093, instr_pc_o=0x0, stall_o=0 that cycle.
REQ-034 pc_i=0x8, mem_ack_i delayed 4 cycles -> mem_req_o=1 and mem_addr_o=0x8 stable for 5 cycles, stall_o=1 throughout, then VALID.
REQ-035 VALID with pipe_stall_i=1 for 3 cycles -> instr_o held, stall_o=1; pipe_stall_i=0 -> stall_o=0 one cycle, next cycle IDLE.
REQ-036 flush_i=1 in REQ with no ack, ack 2 cycles later with 0xDEADBEEF -> state DROP, instr_valid_o stays 0, 0xDEADBEEF never appears valid, next fetch uses new pc_i.
REQ-037 rst_i pulsed low mid-REQ -> mem_req_o=0 and instr_valid_o=0 immediately, outputs 0, fetch restarts from IDLE.
REQ-038 With IF_MISALIGN_CHK_EN, pc_i=0x6 -> no mem_req_o, VALID next cycle, misalign_o=1, instr_o=0x0; without macro -> mem_addr_o=0x6, misalign_o=0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch FSM (IDLE/REQ/VALID/DROP) between the PC register, instruction memory and decode.
// Latency: 3 cycles minimum per instruction. Waits indefinitely on mem_ack_i; holds the instruction while pipe_stall_i=1.
// Optional IF_MISALIGN_CHK_EN: a misaligned pc goes straight to VALID with a zero instruction and misalign_o=1.
module if_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        pipe_stall_i,
  input  logic        flush_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, DROP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] ipc_q;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_q;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            addr_q <= pc_i;
`ifdef IF_MISALIGN_CHK_EN
            if (pc_i[1:0] != 2'b00) begin
              state      <= VALID;
              instr_q    <= '0;
              ipc_q      <= pc_i;
              misalign_q <= 1'b1;
            end else begin
              state <= REQ;
            end
`else
            state <= REQ;
`endif
          end
        end
        REQ: begin
          // A flush without ack must still absorb the outstanding response.
          if (flush_i) begin
            state <= mem_ack_i ? IDLE : DROP;
          end else if (mem_ack_i) begin
            state   <= VALID;
            instr_q <= mem_data_i;
            ipc_q   <= addr_q;
          end
        end
        DROP: begin
          if (mem_ack_i) begin
            state <= IDLE;
          end
        end
        VALID: begin
          if (flush_i || !pipe_stall_i) begin
            state <= IDLE;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o     = (state == REQ) || (state == DROP);
  assign mem_addr_o    = addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = (state == VALID);
  // PC advances once per consumed instruction or once per redirect.
  assign stall_o       = !(flush_i || ((state == VALID) && !pipe_stall_i));
`ifdef IF_MISALIGN_CHK_EN
  assign misalign_o    = misalign_q;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed table-driven bench for if_fetch, plus hand sequences for mid-fetch reset and misaligned pc.
module tb_if_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pipe_stall_i;
  logic        flush_i;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        stall_o;
  logic        misalign_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  if_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .pipe_stall_i(pipe_stall_i), .flush_i(flush_i), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        pstall;
    logic        flush;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_stall;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(logic st, logic [31:0] pc, logic ps, logic fl, logic ak,
                              logic [31:0] d, logic rq, logic [31:0] ad, logic vl,
                              logic [31:0] ins, logic [31:0] ipc, logic sl);
    vec_t v;
    v.start = st; v.pc = pc; v.pstall = ps; v.flush = fl; v.ack = ak; v.data = d;
    v.e_req = rq; v.e_addr = ad; v.e_valid = vl; v.e_instr = ins; v.e_ipc = ipc; v.e_stall = sl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] pc, input logic ps,
                       input logic fl, input logic ak, input logic [31:0] d);
    start_i = st; pc_i = pc; pipe_stall_i = ps; flush_i = fl; mem_ack_i = ak; mem_data_i = d;
  endtask

  initial begin
    //           start pc        pst fl ack data          req addr      vld instr         ipc       stall
    vecs[0]  = mk(1, 32'h0,  0, 0, 1, 32'h00500093, 0, 32'h0,  0, 32'h0,        32'h0,  1);
    vecs[1]  = mk(1, 32'h0,  0, 0, 1, 32'h00500093, 1, 32'h0,  0, 32'h0,        32'h0,  1);
    vecs[2]  = mk(0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h00500093, 32'h0,  0);
    vecs[3]  = mk(1, 32'h8,  0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00500093, 32'h0,  1);
    for (int i = 4; i < 8; i++)
      vecs[i] = mk(1, 32'h8, 0, 0, 0, 32'h0,        1, 32'h8,  0, 32'h00500093, 32'h0,  1);
    vecs[8]  = mk(1, 32'h8,  0, 0, 1, 32'h00A00113, 1, 32'h8,  0, 32'h00500093, 32'h0,  1);
    vecs[9]  = mk(0, 32'h8,  1, 0, 1, 32'hFFFFFFFF, 0, 32'h0,  1, 32'h00A00113, 32'h8,  1);
    vecs[10] = mk(0, 32'h8,  1, 0, 0, 32'h0,        0, 32'h0,  1, 32'h00A00113, 32'h8,  1);
    vecs[11] = mk(0, 32'h8,  1, 0, 0, 32'h0,        0, 32'h0,  1, 32'h00A00113, 32'h8,  1);
    vecs[12] = mk(0, 32'h8,  0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h00A00113, 32'h8,  0);
    vecs[13] = mk(0, 32'hC,  0, 0, 1, 32'h11111111, 0, 32'h0,  0, 32'h00A00113, 32'h8,  1);
    vecs[14] = mk(0, 32'hC,  0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00A00113, 32'h8,  1);
    vecs[15] = mk(1, 32'hC,  0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00A00113, 32'h8,  1);
    vecs[16] = mk(1, 32'hC,  0, 1, 0, 32'h0,        1, 32'hC,  0, 32'h00A00113, 32'h8,  0);
    vecs[17] = mk(1, 32'h40, 0, 0, 0, 32'h0,        1, 32'hC,  0, 32'h00A00113, 32'h8,  1);
    vecs[18] = mk(1, 32'h40, 0, 0, 1, 32'hDEADBEEF, 1, 32'hC,  0, 32'h00A00113, 32'h8,  1);
    vecs[19] = mk(1, 32'h40, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00A00113, 32'h8,  1);
    vecs[20] = mk(1, 32'h40, 0, 0, 1, 32'h00000013, 1, 32'h40, 0, 32'h00A00113, 32'h8,  1);
    vecs[21] = mk(0, 32'h44, 1, 1, 0, 32'h0,        0, 32'h0,  1, 32'h00000013, 32'h40, 0);
    vecs[22] = mk(1, 32'h50, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00000013, 32'h40, 1);
    vecs[23] = mk(1, 32'h50, 0, 1, 1, 32'hBADBAD00, 1, 32'h50, 0, 32'h00000013, 32'h40, 0);
    vecs[24] = mk(0, 32'h50, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h00000013, 32'h40, 1);

    rst_i = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 32'h0);
    @(negedge clk_i); #1;
    check("rst_req",   {31'b0, mem_req_o},     32'd0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o},       32'd1);
    check("rst_instr", instr_o,                32'h0);
    check("rst_ipc",   instr_pc_o,             32'h0);
    check("rst_addr",  mem_addr_o,             32'h0);
    check("rst_mis",   {31'b0, misalign_o},    32'd0);
    flush_i = 1'b1; #1;
    check("rst_flush_stall", {31'b0, stall_o}, 32'd0);
    flush_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].pc, vecs[i].pstall, vecs[i].flush, vecs[i].ack, vecs[i].data);
      #1;
      check($sformatf("v%0d_req", i),   {31'b0, mem_req_o},     {31'b0, vecs[i].e_req});
      if (vecs[i].e_req)
        check($sformatf("v%0d_addr", i), mem_addr_o,            vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_instr", i), instr_o,                vecs[i].e_instr);
      check($sformatf("v%0d_ipc", i),   instr_pc_o,             vecs[i].e_ipc);
      check($sformatf("v%0d_stall", i), {31'b0, stall_o},       {31'b0, vecs[i].e_stall});
      check($sformatf("v%0d_mis", i),   {31'b0, misalign_o},    32'd0);
      @(negedge clk_i);
    end

    // Reset pulse in the middle of an outstanding request.
    drive(1, 32'h100, 0, 0, 0, 32'h0);
    @(negedge clk_i); #1;
    check("mr_req_before",  {31'b0, mem_req_o}, 32'd1);
    check("mr_addr_before", mem_addr_o,         32'h100);
    rst_i = 1'b0; start_i = 1'b0; #1;
    check("mr_req",   {31'b0, mem_req_o},     32'd0);
    check("mr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("mr_addr",  mem_addr_o,             32'h0);
    check("mr_instr", instr_o,                32'h0);
    check("mr_ipc",   instr_pc_o,             32'h0);
    check("mr_stall", {31'b0, stall_o},       32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 32'h100, 0, 0, 1, 32'hCAFEF00D);
    @(negedge clk_i); #1;
    check("mr_late_ack_valid", {31'b0, instr_valid_o}, 32'd0);
    check("mr_late_ack_req",   {31'b0, mem_req_o},     32'd0);
    check("mr_late_ack_instr", instr_o,                32'h0);
    drive(1, 32'h104, 0, 0, 1, 32'h00300193);
    @(negedge clk_i); #1;
    check("mr_restart_req", {31'b0, mem_req_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk_i); #1;
    check("mr_restart_valid", {31'b0, instr_valid_o}, 32'd1);
    check("mr_restart_instr", instr_o,                32'h00300193);
    check("mr_restart_ipc",   instr_pc_o,             32'h104);
    drive(0, 32'h108, 0, 0, 0, 32'h0);
    @(negedge clk_i);

    // Misaligned pc.
    drive(1, 32'h6, 0, 0, 0, 32'h0);
    @(negedge clk_i); #1;
`ifdef IF_MISALIGN_CHK_EN
    check("mis_req",   {31'b0, mem_req_o},     32'd0);
    check("mis_valid", {31'b0, instr_valid_o}, 32'd1);
    check("mis_flag",  {31'b0, misalign_o},    32'd1);
    check("mis_instr", instr_o,                32'h0);
    check("mis_ipc",   instr_pc_o,             32'h6);
    start_i = 1'b0;
    @(negedge clk_i); #1;
    check("mis_clear_flag",  {31'b0, misalign_o},    32'd0);
    check("mis_clear_valid", {31'b0, instr_valid_o}, 32'd0);
`else
    check("mis_req",  {31'b0, mem_req_o},     32'd1);
    check("mis_addr", mem_addr_o,             32'h6);
    check("mis_flag", {31'b0, misalign_o},    32'd0);
    drive(0, 32'h6, 0, 0, 1, 32'h12345678);
    @(negedge clk_i); #1;
    check("mis_valid", {31'b0, instr_valid_o}, 32'd1);
    check("mis_instr", instr_o,                32'h12345678);
    check("mis_ipc",   instr_pc_o,             32'h6);
    check("mis_flag2", {31'b0, misalign_o},    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
